// File: rtl/tmac_uni_ctrl.sv
// -----------------------------------------------------------------------------
// tmac_uni_ctrl
//
// Transaction controller for the 16-lane unipolar stochastic MAC
// (tMAC_uni_nonscaled). One transaction works like this:
//   1. Accept one operand set over in_valid/in_ready and register it.
//   2. Pulse the MAC load strobes for one cycle.
//   3. Wait out the MAC adder-tree pipeline (PIPE_LAT cycles).
//   4. Count ones on mac_oC over ACC_LEN cycles.
//   5. Present the count on result over out_valid/out_ready.
//
// Fixed latency from accept to out_valid is 1 + 1 + PIPE_LAT + ACC_LEN cycles.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand-set handshake (in_ready high only in IDLE)
//   in_a, in_b           packed operands, lane i at [i*DATA_W +: DATA_W]
//   mac_a, mac_b         registered operands to the MAC iA / iB
//   mac_loadA/B          one-cycle load strobes to the MAC
//   mac_oC               MAC output bitstream
//   out_valid/out_ready  result handshake
//   result               number of ones seen on mac_oC within the window
//   busy                 high in every state except IDLE
// -----------------------------------------------------------------------------
module tmac_uni_ctrl #(
    parameter int DATA_W   = 8,
    parameter int LANES    = 16,
    parameter int PIPE_LAT = 3,
    parameter int ACC_LEN  = 256,
    parameter int RES_W    = $clog2(ACC_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_a,
    input  logic [LANES*DATA_W-1:0]  in_b,

    output logic [LANES*DATA_W-1:0]  mac_a,
    output logic [LANES*DATA_W-1:0]  mac_b,
    output logic                     mac_loadA,
    output logic                     mac_loadB,
    input  logic                     mac_oC,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         result,

    output logic                     busy
);

    // The phase counter is shared by WAIT and ACC, so it is sized for the
    // longer of the two (never narrower than one bit).
    localparam int CNT_MAX = (ACC_LEN > PIPE_LAT) ? ((ACC_LEN > 2) ? ACC_LEN : 2)
                                                  : ((PIPE_LAT > 2) ? PIPE_LAT : 2);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACC_LEN - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_ACC,
        S_DONE
    } state_t;

    state_t                    state_q;
    logic [LANES*DATA_W-1:0]   mac_a_q;
    logic [LANES*DATA_W-1:0]   mac_b_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [RES_W-1:0]          acc_q;
    logic [RES_W-1:0]          acc_d;
    logic [RES_W-1:0]          result_q;
    logic                      load_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      busy_q;

    // Running sum including the current bit. Used both for the per-cycle
    // accumulate and for the final result so the last window bit is counted.
    // NOTE: a combinational block assigns every output on every path, so no
    // latch can be inferred.
    always_comb begin
        acc_d = acc_q + RES_W'(mac_oC);
    end

    // Single-process FSM; every output is a register written alongside the
    // state transition that implies it, so outputs are glitch-free.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side reads the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide operand and result registers are reset too,
            // because the outputs they drive must read 0 immediately on reset.
            state_q     <= S_IDLE;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            load_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // The load strobe is a single-cycle pulse; it is re-armed only on
            // the IDLE->LOAD transition below.
            load_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mac_a_q    <= in_a;
                        mac_b_q    <= in_b;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        load_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    cnt_q <= '0;
                    if (PIPE_LAT == 0) begin
                        state_q <= S_ACC;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_ACC;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_ACC: begin
                    acc_q <= acc_d;
                    if (cnt_q == ACC_LAST) begin
                        cnt_q       <= '0;
                        result_q    <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // in_valid is deliberately not looked at here: the output
                    // handshake always wins and the next accept happens in IDLE.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_loadA = load_q;
    assign mac_loadB = load_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tmac_uni_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tmac_uni_ctrl
//
// Directed bench for tmac_uni_ctrl with default parameters. Inputs are driven
// and outputs sampled on the falling edge; the DUT acts on the rising edge.
// Cycle index k counts rising edges after the accept edge, so cycle k=1 is
// LOAD, k=2..4 WAIT, k=5..260 ACC and k=261 the first DONE cycle.
// -----------------------------------------------------------------------------
module tb_tmac_uni_ctrl;

    localparam int DATA_W = 8;
    localparam int LANES  = 16;
    localparam int W      = LANES * DATA_W;
    localparam int RES_W  = 9;
    localparam int LAT    = 261;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [W-1:0]     mac_a;
    logic [W-1:0]     mac_b;
    logic             mac_loadA;
    logic             mac_loadB;
    logic             mac_oC;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] result;
    logic             busy;

    int total;
    int bad;

    tmac_uni_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_loadA (mac_loadA),
        .mac_loadB (mac_loadB),
        .mac_oC    (mac_oC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mac_oC pattern for cycle k of a transaction.
    //   0: constant 0          1: constant 1
    //   2: 1,0,1,0.. starting at first ACC cycle, 1 outside the window
    //   3: 1 only on the last WAIT cycle and the cycle after ACC
    function automatic logic oc_of(input int mode, input int k);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (k >= 5 && k <= 260) ? ((k - 5) % 2 == 0) : 1'b1;
            3:       return (k == 4) || (k == 261);
            default: return 1'b0;
        endcase
    endfunction

    // Accept one operand set and run it to cycle stop_k (LAT for a full run).
    // Spurious in_valid pulses with different operands are driven while busy.
    task automatic run_txn(input int mode, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [RES_W-1:0] exp_res, input int stop_k);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL txn_idle_ready: in_ready=%b want 1", in_ready);
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        mac_oC   = oc_of(mode, 0);
        for (int k = 1; k <= stop_k; k++) begin
            @(negedge clk);
            total++;
            if (mac_loadA !== (k == 1) || mac_loadB !== (k == 1)) begin
                bad++;
                $display("FAIL txn_load k=%0d: loadA=%b loadB=%b want %b", k, mac_loadA, mac_loadB, k == 1);
            end
            total++;
            if (out_valid !== (k >= LAT)) begin
                bad++;
                $display("FAIL txn_out_valid k=%0d: out_valid=%b want %b", k, out_valid, k >= LAT);
            end
            total++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL txn_busy k=%0d: busy=%b in_ready=%b want 1/0", k, busy, in_ready);
            end
            total++;
            if (mac_a !== a || mac_b !== b) begin
                bad++;
                $display("FAIL txn_operands k=%0d: mac_a=%h mac_b=%h want %h %h", k, mac_a, mac_b, a, b);
            end
            if (k == LAT) begin
                total++;
                if (result !== exp_res) begin
                    bad++;
                    $display("FAIL txn_result mode=%0d: result=%0d want %0d", mode, result, exp_res);
                end
            end
            mac_oC   = oc_of(mode, k);
            in_valid = (k % 7 == 0);
            in_a     = ~a;
            in_b     = ~b;
        end
        in_valid = 1'b0;
    endtask

    // Complete the output handshake and check the return to IDLE.
    task automatic finish_txn(input logic [RES_W-1:0] exp_res);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        mac_oC    = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL finish_idle: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
        total++;
        if (result !== exp_res) begin
            bad++;
            $display("FAIL finish_result_hold: result=%0d want %0d", result, exp_res);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        mac_oC    = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || mac_loadA !== 1'b0 || mac_loadB !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: out_valid=%b loadA=%b loadB=%b busy=%b want 0", out_valid, mac_loadA, mac_loadB, busy);
        end
        total++;
        if (result !== '0 || mac_a !== '0 || mac_b !== '0) begin
            bad++;
            $display("FAIL reset_data: result=%0d mac_a=%h mac_b=%h want 0", result, mac_a, mac_b);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    // Basic accept / latency, plus the window-counting patterns.
    task automatic test_windows();
        run_txn(1, {LANES{8'h80}}, {LANES{8'h40}}, 9'd256, LAT);
        finish_txn(9'd256);
        run_txn(0, {LANES{8'h11}}, {LANES{8'h22}}, 9'd0, LAT);
        finish_txn(9'd0);
        run_txn(2, {LANES{8'h33}}, {LANES{8'h44}}, 9'd128, LAT);
        finish_txn(9'd128);
        run_txn(3, {LANES{8'h55}}, {LANES{8'h66}}, 9'd0, LAT);
        finish_txn(9'd0);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a;
        a = {LANES{8'hA5}};
        run_txn(2, a, {LANES{8'h5A}}, 9'd128, LAT);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== 9'd128) begin
                bad++;
                $display("FAIL hold_result i=%0d: out_valid=%b result=%0d want 1/128", i, out_valid, result);
            end
            total++;
            if (in_ready !== 1'b0 || mac_loadA !== 1'b0 || mac_a !== a) begin
                bad++;
                $display("FAIL hold_no_accept i=%0d: in_ready=%b loadA=%b mac_a=%h want 0/0/%h", i, in_ready, mac_loadA, mac_a, a);
            end
            in_valid = (i % 2 == 0);
            in_a     = {LANES{8'h3C}};
            mac_oC   = 1'b1;
        end
        in_valid = 1'b0;
        finish_txn(9'd128);
    endtask

    task automatic test_reset_mid_acc();
        run_txn(1, {LANES{8'hC3}}, {LANES{8'h3C}}, 9'd256, 104);
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || mac_loadA !== 1'b0 || busy !== 1'b0 || result !== '0
            || mac_a !== '0 || mac_b !== '0) begin
            bad++;
            $display("FAIL async_reset: out_valid=%b loadA=%b busy=%b result=%0d mac_a=%h mac_b=%h want 0",
                     out_valid, mac_loadA, busy, result, mac_a, mac_b);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        mac_oC = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_to_idle: in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
        run_txn(1, {LANES{8'h0F}}, {LANES{8'hF0}}, 9'd256, LAT);
        finish_txn(9'd256);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1;
        logic [W-1:0] a2;
        logic [W-1:0] exp_a;
        a1 = {LANES{8'h12}};
        a2 = {LANES{8'h34}};
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_a      = a1;
        in_b      = a1;
        mac_oC    = 1'b0;
        for (int k = 1; k <= 524; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== (k == 261 || k == 523)) begin
                bad++;
                $display("FAIL b2b_out_valid k=%0d: out_valid=%b", k, out_valid);
            end
            total++;
            if (mac_loadA !== (k == 1 || k == 263)) begin
                bad++;
                $display("FAIL b2b_load k=%0d: loadA=%b", k, mac_loadA);
            end
            total++;
            if (in_ready !== (k == 262 || k == 524)) begin
                bad++;
                $display("FAIL b2b_in_ready k=%0d: in_ready=%b", k, in_ready);
            end
            exp_a = (k < 263) ? a1 : a2;
            total++;
            if (mac_a !== exp_a) begin
                bad++;
                $display("FAIL b2b_operands k=%0d: mac_a=%h want %h", k, mac_a, exp_a);
            end
            if (k >= 261) begin
                total++;
                if (result !== ((k >= 523) ? 9'd256 : 9'd0)) begin
                    bad++;
                    $display("FAIL b2b_result k=%0d: result=%0d want %0d", k, result, (k >= 523) ? 256 : 0);
                end
            end
            if (k == 262) begin
                in_a = a2;
                in_b = a2;
            end
            mac_oC = (k >= 263);
            if (k == 523) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        mac_oC    = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_windows();
        test_backpressure();
        test_reset_mid_acc();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmac_uni_ctrl.md
Name: tmac_uni_ctrl

Overview:
Transaction controller for the 16-lane unipolar stochastic MAC (tMAC_uni_nonscaled).
- Accepts one operand set (16 A and 16 B values) per transaction over a valid/ready handshake and holds it stable for the MAC.
- Pulses the MAC's loadA/loadB, then waits out the MAC's adder-tree pipeline latency.
- Counts ones on the MAC's oC bitstream over a fixed window, and returns the binary count over a valid/ready handshake.

Parameters:
- DATA_W, 8, operand width per lane.
- LANES, 16, number of MAC lanes.
- PIPE_LAT, 3, cycles from load to the first meaningful oC bit (cnt, sum0 and sum register stages).
- ACC_LEN, 256, length of the oC accumulation window in cycles (one full 8-bit Sobol period).
- RES_W, $clog2(ACC_LEN+1) = 9, result width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand set valid.
- in_ready  out  1  controller can accept an operand set.
- in_a  in  LANES*DATA_W  packed A operands; lane i is bits [i*DATA_W +: DATA_W].
- in_b  in  LANES*DATA_W  packed B operands, same packing as in_a.
- mac_a  out  LANES*DATA_W  registered A operands to the MAC iA.
- mac_b  out  LANES*DATA_W  registered B operands to the MAC iB.
- mac_loadA  out  1  load strobe to MAC loadA.
- mac_loadB  out  1  load strobe to MAC loadB.
- mac_oC  in  1  MAC output bitstream.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  RES_W  number of ones on mac_oC within the window.
- busy  out  1  high in every state except IDLE.

Behaviour:
Reset (asynchronous, any state): state=IDLE; mac_a, mac_b, result, phase counter and accumulator all 0; mac_loadA=mac_loadB=out_valid=busy=0. After reset, in_ready=1.

FSM states: IDLE, LOAD, WAIT, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: register in_a/in_b into mac_a/mac_b, clear accumulator and phase counter, go to LOAD.
- LOAD (1 cycle):
  - mac_loadA=mac_loadB=1, both driven from a registered state decode.
  - Go to WAIT, phase counter=0.
- WAIT (PIPE_LAT cycles):
  - Phase counter increments each cycle.
  - When counter==PIPE_LAT-1, go to ACC with counter=0.
  - PIPE_LAT=0 skips WAIT (LOAD goes directly to ACC).
- ACC (ACC_LEN cycles):
  - Accumulator += mac_oC each cycle.
  - When counter==ACC_LEN-1, result <= accumulator + mac_oC, so the final bit is included; go to DONE.
- DONE:
  - out_valid=1 and result held stable until out_ready.
  - On out_valid && out_ready, go to IDLE next cycle.

General rules:
- in_ready=1 only in IDLE. in_valid outside IDLE is ignored; there is no overlap and no queueing.
- mac_a/mac_b change only on input acceptance and hold through DONE and IDLE.
- result holds its last value after handshake until the next ACC completion.
- Accumulator width RES_W, so ACC_LEN ones fit without wrap; all-ones gives result=ACC_LEN.
- Fixed latency, accept to out_valid: 1 + 1 + PIPE_LAT + ACC_LEN cycles = 261 with defaults.
- DONE with out_ready=1 on entry: handshake completes in the first DONE cycle (out_valid high for exactly 1 cycle).
- Simultaneous out_ready and in_valid in DONE: only the output handshake is taken. The new input is accepted in IDLE on the following cycle at the earliest.
- The controller does not reset the MAC's internal counters or RNGs; the system issues rst_n between jobs when absolute results are required.

Test Plan:
1. Assert rst_n low, then release -> out_valid=0, mac_loadA=mac_loadB=0, busy=0, result=0, in_ready=1.
2. Accept one set (in_a lanes=0x80, in_b lanes=0x40) at cycle T -> mac_a/mac_b updated at T+1; mac_loadA=mac_loadB=1 only at T+1; out_valid rises at T+261; busy high T+1..handshake.
3. Drive mac_oC constant 1 -> result=256. Constant 0 -> result=0. Alternating 1,0 starting with 1 in the first ACC cycle -> result=128. Assert a 1 only on the last WAIT cycle and on the cycle after ACC -> result=0.
4. Hold out_ready=0 for 20 cycles in DONE while pulsing in_valid -> out_valid and result stable, in_ready=0, no new load pulse. Then out_ready=1 -> IDLE next cycle, in_ready=1.
5. Assert rst_n low mid-ACC (cycle 100 of the window) -> all outputs 0 immediately (asynchronous); after release, state is IDLE and a new transaction completes with the full 261-cycle latency.
6. Two back-to-back transactions with out_ready tied 1 and in_valid tied 1 -> second accept occurs on the cycle after the first result handshake; second result reflects only the second window.
